// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction-memory address, absorbs the
// memory's one-cycle read latency and hands pc/instruction pairs to decode.
module fetch_unit #(
    parameter int                PC_W     = 10,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                 CLK_SYS,
    input  logic                 RST_SYS,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic [PC_W-1:0]      pc,
    input  logic [INSTR_W-1:0]   instr_in,
    output logic [INSTR_W-1:0]   if_instr,
    output logic [PC_W-1:0]      if_pc,
    output logic                 if_valid,
    output logic [CNT_W-1:0]     fetch_count
);

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_req_pc;
    logic             r_req_valid;
    logic [PC_W-1:0]  w_redirect_next;

    // On stall the in-flight address is replayed so instr_in stays stable.
    always_comb begin
        if (redirect_valid)
            pc = redirect_pc;
        else if (stall)
            pc = r_req_pc;
        else
            pc = r_pc;
    end

    assign w_redirect_next = redirect_pc + PC_W'(1);

    always_ff @(posedge CLK_SYS or posedge RST_SYS) begin
        if (RST_SYS) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_req_valid <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // The word arriving now is wrong-path: squash it, keep old if_* data.
            r_pc        <= w_redirect_next;
            r_req_pc    <= redirect_pc;
            r_req_valid <= 1'b1;
            if_valid    <= 1'b0;
        end else if (!stall) begin
            r_pc        <= r_pc + PC_W'(1);
            r_req_pc    <= r_pc;
            r_req_valid <= 1'b1;
            if_instr    <= instr_in;
            if_pc       <= r_req_pc;
            if_valid    <= r_req_valid;
            if (r_req_valid)
                fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall and
// redirect traffic, checked against a request-queue reference model.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    logic                CLK_SYS = 1'b0;
    logic                RST_SYS;
    logic                stall;
    logic                redirect_valid;
    logic [PC_W-1:0]     redirect_pc;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  instr_in;
    logic [INSTR_W-1:0]  if_instr;
    logic [PC_W-1:0]     if_pc;
    logic                if_valid;
    logic [CNT_W-1:0]    fetch_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .CLK_SYS        (CLK_SYS),
        .RST_SYS        (RST_SYS),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr_in       (instr_in),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .fetch_count    (fetch_count)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    // Registered instruction memory: mem[a] = 0xA5000000 | a.
    always @(posedge CLK_SYS)
        instr_in <= 32'hA500_0000 | {22'd0, pc};

    // Reference model: a queue of requested-but-undelivered addresses.
    int              m_q[$];
    logic [PC_W-1:0] m_fetch;
    logic [PC_W-1:0] m_last_req;
    logic            m_valid;
    logic [PC_W-1:0] m_pc;
    int              m_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch    = '0;
        m_last_req = '0;
        m_valid    = 1'b0;
        m_pc       = '0;
        m_count    = 0;
    endtask

    function automatic logic [PC_W-1:0] model_pc();
        if (redirect_valid) return redirect_pc;
        if (stall)          return m_last_req;
        return m_fetch;
    endfunction

    task automatic model_edge();
        if (redirect_valid) begin
            m_q.delete();
            m_valid = 1'b0;
            m_q.push_back(int'(redirect_pc));
            m_last_req = redirect_pc;
            m_fetch    = redirect_pc + 10'd1;
        end else if (!stall) begin
            if (m_q.size() > 0) begin
                m_pc    = PC_W'(m_q.pop_front());
                m_valid = 1'b1;
                m_count++;
            end else begin
                m_valid = 1'b0;
            end
            m_q.push_back(int'(m_fetch));
            m_last_req = m_fetch;
            m_fetch    = m_fetch + 10'd1;
        end
    endtask

    task automatic check_outputs();
        check_val("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check_val("if_pc", {22'd0, if_pc}, {22'd0, m_pc});
            check_val("if_instr", if_instr, 32'hA500_0000 | {22'd0, m_pc});
        end
        check_val("fetch_count", {16'd0, fetch_count}, 32'(m_count[CNT_W-1:0]));
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic s, input logic rv, input logic [PC_W-1:0] rp);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        check_val("pc", {22'd0, pc}, {22'd0, model_pc()});
        @(posedge CLK_SYS);
        model_edge();
        @(negedge CLK_SYS);
        check_outputs();
        $display("cyc stall=%0d redir=%0d rpc=%0d pc=%0d -> if_valid=%0d if_pc=%0d if_instr=%08h cnt=%0d",
                 s, rv, rp, pc, if_valid, if_pc, if_instr, fetch_count);
    endtask

    task automatic run_until_if_pc(input logic [PC_W-1:0] target);
        for (int i = 0; i < 2000; i++) begin
            if (if_valid && if_pc == target) return;
            cycle(1'b0, 1'b0, '0);
        end
        check_val("wait_if_pc_timeout", {22'd0, if_pc}, {22'd0, target});
    endtask

    task automatic async_reset();
        #2;
        RST_SYS = 1'b1;
        #1;
        check_val("arst_if_valid", {31'd0, if_valid}, 32'd0);
        check_val("arst_if_pc", {22'd0, if_pc}, 32'd0);
        check_val("arst_fetch_count", {16'd0, fetch_count}, 32'd0);
        check_val("arst_if_instr", if_instr, 32'd0);
        model_reset();
        stall = 1'b0;
        redirect_valid = 1'b0;
        @(posedge CLK_SYS);
        @(negedge CLK_SYS);
        RST_SYS = 1'b0;
        $display("async reset applied and released at %0t", $time);
    endtask

    initial begin
        RST_SYS        = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(negedge CLK_SYS);
        check_val("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_val("rst_if_pc", {22'd0, if_pc}, 32'd0);
        check_val("rst_if_instr", if_instr, 32'd0);
        check_val("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
        check_val("rst_pc", {22'd0, pc}, 32'd0);
        RST_SYS = 1'b0;

        // Startup latency and a stall while if_pc=5.
        run_until_if_pc(10'd5);
        check_val("first_five_count", {16'd0, fetch_count}, 32'd6);
        repeat (3) cycle(1'b1, 1'b0, '0);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Redirect while if_pc=8 (already past it: restart and reach 8).
        redirect_valid = 1'b0;
        cycle(1'b0, 1'b1, 10'd6);
        run_until_if_pc(10'd8);
        cycle(1'b0, 1'b1, 10'h200);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Redirect together with stall: redirect wins.
        cycle(1'b1, 1'b1, 10'h300);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Wrap through 1022, 1023, 0.
        cycle(1'b0, 1'b1, 10'd1020);
        repeat (6) cycle(1'b0, 1'b0, '0);

        // Async reset mid-stream while if_valid=1.
        async_reset();
        repeat (4) cycle(1'b0, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic            s, rv;
            logic [PC_W-1:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 3) == 0) ? PC_W'(1020 + $urandom_range(0, 3))
                                              : PC_W'($urandom_range(0, 1023));
            cycle(s, rv, rp);
            if (i == 700) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
